// File: rtl/if_stage_if.sv
// if_stage_if: request-stage, inst_sram response and decode
// handshake signals seen by the fetch stage.
interface if_stage_if;
  logic         pfs_to_fs_valid;
  logic [103:0] pfs_to_fs_bus;
  logic         fs_allowin;
  logic         fs_valid;
  logic         fs_inst_unable;
  logic         pfs_inst_waiting;
  logic         inst_sram_data_ok;
  logic [31:0]  inst_sram_rdata;
  logic         ds_allowin;
  logic         fs_to_ds_valid;
  logic [102:0] fs_to_ds_bus;
  logic         do_flush;

  modport master (
    output pfs_to_fs_valid,
    output pfs_to_fs_bus,
    input  fs_allowin,
    input  fs_valid,
    input  fs_inst_unable,
    output pfs_inst_waiting,
    output inst_sram_data_ok,
    output inst_sram_rdata,
    output ds_allowin,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    output do_flush
  );

  modport slave (
    input  pfs_to_fs_valid,
    input  pfs_to_fs_bus,
    output fs_allowin,
    output fs_valid,
    output fs_inst_unable,
    input  pfs_inst_waiting,
    input  inst_sram_data_ok,
    input  inst_sram_rdata,
    input  ds_allowin,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    input  do_flush
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage; owns one inst_sram response
// per entry and discards responses orphaned by a flush.
module if_stage (
  input  logic      clk,
  input  logic      reset,
  if_stage_if.slave io
);
  typedef struct packed {
    logic        tlb_refill;
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic        ex;
    logic [31:0] pc;
  } fs_bus_t;

  fs_bus_t     fs_bus_r;
  fs_bus_t     pfs_in;
  logic        pfs_inst_ok;
  logic [31:0] pfs_inst;

  logic        fs_valid_r;
  logic        fs_inst_ok_r;
  logic [31:0] fs_inst_r;
  logic [1:0]  cancel_cnt;
  logic [1:0]  cancel_nxt;

  logic        ex_r;
  logic        cnt_zero;
  logic        fs_waiting;
  logic        fs_data_hit;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] out_inst;

  assign {pfs_in.tlb_refill, pfs_inst_ok, pfs_inst,
          pfs_in.excode, pfs_in.badvaddr,
          pfs_in.ex, pfs_in.pc} = io.pfs_to_fs_bus;

  assign ex_r        = fs_bus_r.ex;
  assign cnt_zero    = (cancel_cnt == 2'd0);
  assign fs_waiting  = fs_valid_r & ~fs_inst_ok_r & ~ex_r;
  assign fs_data_hit = fs_waiting & io.inst_sram_data_ok
                     & cnt_zero;
  assign fs_ready_go = fs_inst_ok_r | ex_r | fs_data_hit;
  assign fs_allowin  = ~fs_valid_r
                     | (fs_ready_go & io.ds_allowin);

  // Every response in flight at a flush becomes a discard,
  // minus the one (if any) arriving in the flush cycle itself.
  assign cancel_nxt = cancel_cnt
                    + {1'b0, fs_waiting}
                    + {1'b0, io.pfs_inst_waiting}
                    - {1'b0, io.inst_sram_data_ok};

  always_comb begin
    out_inst = '0;
    if (fs_valid_r && !ex_r)
      out_inst = fs_inst_ok_r ? fs_inst_r
                              : io.inst_sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_r   <= 1'b0;
      fs_bus_r     <= '0;
      fs_inst_ok_r <= 1'b0;
      fs_inst_r    <= '0;
      cancel_cnt   <= '0;
    end else if (io.do_flush) begin
      fs_valid_r   <= 1'b0;
      fs_inst_ok_r <= 1'b0;
      cancel_cnt   <= cancel_nxt;
    end else begin
      if (io.inst_sram_data_ok && !cnt_zero)
        cancel_cnt <= cancel_cnt - 2'd1;
      if (fs_allowin) begin
        fs_valid_r <= io.pfs_to_fs_valid;
        if (io.pfs_to_fs_valid) begin
          fs_bus_r     <= pfs_in;
          fs_inst_ok_r <= pfs_inst_ok;
          fs_inst_r    <= pfs_inst;
        end
      end else if (fs_data_hit) begin
        fs_inst_ok_r <= 1'b1;
        fs_inst_r    <= io.inst_sram_rdata;
      end
    end
  end

  assign io.fs_allowin     = fs_allowin;
  assign io.fs_valid       = fs_valid_r;
  assign io.fs_inst_unable = ~fs_waiting & cnt_zero;
  assign io.fs_to_ds_valid = fs_valid_r & fs_ready_go
                           & ~io.do_flush;
  assign io.fs_to_ds_bus   = {fs_bus_r.tlb_refill,
                              fs_bus_r.excode,
                              fs_bus_r.badvaddr,
                              fs_bus_r.ex,
                              out_inst,
                              fs_bus_r.pc};
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch stage.
module tb_if_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_stage_if io();

  if_stage dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit        valid;
    bit        have;
    bit        ex;
    bit        tlb;
    bit [4:0]  ec;
    bit [31:0] bv;
    bit [31:0] pc;
    bit [31:0] inst;
  } slot_t;

  function automatic logic [103:0] mk_pfs(
    logic tlb, logic ok, logic [31:0] inst, logic [4:0] ec,
    logic [31:0] bv, logic ex, logic [31:0] pc);
    return {tlb, ok, inst, ec, bv, ex, pc};
  endfunction

  function automatic logic [102:0] mk_ds(
    logic tlb, logic [4:0] ec, logic [31:0] bv, logic ex,
    logic [31:0] inst, logic [31:0] pc);
    return {tlb, ec, bv, ex, inst, pc};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    io.pfs_to_fs_valid   = 1'b0;
    io.pfs_to_fs_bus     = '0;
    io.pfs_inst_waiting  = 1'b0;
    io.inst_sram_data_ok = 1'b0;
    io.inst_sram_rdata   = '0;
    io.ds_allowin        = 1'b0;
    io.do_flush          = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    io.inst_sram_rdata = 32'hffffffff;
    #1;
    total++;
    if (io.fs_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_fs_valid got=%0b want=0", io.fs_valid);
    end
    total++;
    if (io.fs_allowin !== 1'b1) begin
      bad++;
      $display("FAIL reset_allowin got=%0b want=1", io.fs_allowin);
    end
    total++;
    if (io.fs_to_ds_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_to_ds_valid got=%0b want=0",
               io.fs_to_ds_valid);
    end
    total++;
    if (io.fs_inst_unable !== 1'b1) begin
      bad++;
      $display("FAIL reset_unable got=%0b want=1", io.fs_inst_unable);
    end
    total++;
    if (io.fs_to_ds_bus !== 103'd0) begin
      bad++;
      $display("FAIL reset_bus got=%h want=0", io.fs_to_ds_bus);
    end
    total++;
    if (dut.cancel_cnt !== 2'd0) begin
      bad++;
      $display("FAIL reset_cancel got=%0d want=0", dut.cancel_cnt);
    end
  endtask

  task automatic test_pass_through();
    do_reset();
    io.ds_allowin      = 1'b1;
    io.pfs_to_fs_valid = 1'b1;
    io.pfs_to_fs_bus   = mk_pfs(0, 1, 32'h24010001, 0, 0, 0,
                                32'hbfc00000);
    #1;
    total++;
    if (io.fs_allowin !== 1'b1 || io.fs_to_ds_valid !== 1'b0) begin
      bad++;
      $display("FAIL pass_accept got allowin=%0b vld=%0b want 1/0",
               io.fs_allowin, io.fs_to_ds_valid);
    end
    cyc();
    io.pfs_to_fs_valid = 1'b0;
    #1;
    total++;
    if (io.fs_to_ds_valid !== 1'b1) begin
      bad++;
      $display("FAIL pass_valid got=%0b want=1", io.fs_to_ds_valid);
    end
    total++;
    if (io.fs_to_ds_bus !==
        mk_ds(0, 0, 0, 0, 32'h24010001, 32'hbfc00000)) begin
      bad++;
      $display("FAIL pass_bus got=%h want=%h", io.fs_to_ds_bus,
               mk_ds(0, 0, 0, 0, 32'h24010001, 32'hbfc00000));
    end
    cyc();
    #1;
    total++;
    if (io.fs_valid !== 1'b0) begin
      bad++;
      $display("FAIL pass_drain got=%0b want=0", io.fs_valid);
    end
  endtask

  task automatic test_wait_capture();
    int n;
    do_reset();
    io.pfs_to_fs_valid = 1'b1;
    io.pfs_to_fs_bus   = mk_pfs(0, 0, 0, 0, 0, 0, 32'hbfc00004);
    cyc();
    io.pfs_to_fs_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (io.fs_inst_unable !== 1'b0 || io.fs_to_ds_valid !== 1'b0)
      begin
        bad++;
        $display("FAIL wait_idle%0d got unable=%0b vld=%0b want 0/0",
                 i, io.fs_inst_unable, io.fs_to_ds_valid);
      end
      cyc();
    end
    io.inst_sram_data_ok = 1'b1;
    io.inst_sram_rdata   = 32'h3c1d8000;
    #1;
    total++;
    if (io.fs_to_ds_valid !== 1'b1 ||
        io.fs_to_ds_bus[63:32] !== 32'h3c1d8000) begin
      bad++;
      $display("FAIL wait_bypass got vld=%0b inst=%h want 1/3c1d8000",
               io.fs_to_ds_valid, io.fs_to_ds_bus[63:32]);
    end
    cyc();
    io.inst_sram_data_ok = 1'b0;
    io.inst_sram_rdata   = 32'h0badf00d;
    #1;
    total++;
    if (io.fs_inst_unable !== 1'b1 || io.fs_to_ds_valid !== 1'b1 ||
        io.fs_to_ds_bus[63:32] !== 32'h3c1d8000) begin
      bad++;
      $display("FAIL wait_latched got un=%0b vld=%0b inst=%h want 1/1/3c1d8000",
               io.fs_inst_unable, io.fs_to_ds_valid,
               io.fs_to_ds_bus[63:32]);
    end
    cyc();
    io.ds_allowin = 1'b1;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (io.fs_to_ds_valid && io.ds_allowin) begin
        n++;
        total++;
        if (io.fs_to_ds_bus[63:32] !== 32'h3c1d8000 ||
            io.fs_to_ds_bus[31:0] !== 32'hbfc00004) begin
          bad++;
          $display("FAIL wait_deliver got=%h want inst=3c1d8000",
                   io.fs_to_ds_bus);
        end
      end
      cyc();
    end
    total++;
    if (n != 1) begin
      bad++;
      $display("FAIL wait_once got=%0d want=1", n);
    end
  endtask

  task automatic test_exception();
    do_reset();
    io.ds_allowin      = 1'b1;
    io.pfs_to_fs_valid = 1'b1;
    io.pfs_to_fs_bus   = mk_pfs(0, 0, 32'hdeadbeef, 5'h04,
                                32'hbfc00002, 1, 32'hbfc00002);
    cyc();
    io.pfs_to_fs_valid = 1'b0;
    io.inst_sram_rdata = 32'h12345678;
    #1;
    total++;
    if (io.fs_to_ds_valid !== 1'b1 || io.fs_inst_unable !== 1'b1) begin
      bad++;
      $display("FAIL ex_ready got vld=%0b un=%0b want 1/1",
               io.fs_to_ds_valid, io.fs_inst_unable);
    end
    total++;
    if (io.fs_to_ds_bus !==
        mk_ds(0, 5'h04, 32'hbfc00002, 1, 0, 32'hbfc00002)) begin
      bad++;
      $display("FAIL ex_bus got=%h want=%h", io.fs_to_ds_bus,
               mk_ds(0, 5'h04, 32'hbfc00002, 1, 0, 32'hbfc00002));
    end
    cyc();
  endtask

  task automatic test_flush_cancel();
    logic [31:0] w [3];
    w[0] = 32'h11111111;
    w[1] = 32'h22222222;
    w[2] = 32'h33333333;
    do_reset();
    io.pfs_to_fs_valid = 1'b1;
    io.pfs_to_fs_bus   = mk_pfs(0, 0, 0, 0, 0, 0, 32'hbfc00010);
    cyc();
    io.pfs_to_fs_valid  = 1'b0;
    io.do_flush         = 1'b1;
    io.pfs_inst_waiting = 1'b1;
    #1;
    total++;
    if (io.fs_to_ds_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_valid got=%0b want=0", io.fs_to_ds_valid);
    end
    cyc();
    io.do_flush         = 1'b0;
    io.pfs_inst_waiting = 1'b0;
    #1;
    total++;
    if (dut.cancel_cnt !== 2'd2 || io.fs_valid !== 1'b0 ||
        io.fs_inst_unable !== 1'b0) begin
      bad++;
      $display("FAIL flush_cnt got cnt=%0d vld=%0b un=%0b want 2/0/0",
               dut.cancel_cnt, io.fs_valid, io.fs_inst_unable);
    end
    io.pfs_to_fs_valid = 1'b1;
    io.pfs_to_fs_bus   = mk_pfs(0, 0, 0, 0, 0, 0, 32'hbfc00380);
    cyc();
    io.pfs_to_fs_valid = 1'b0;
    io.ds_allowin      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      io.inst_sram_data_ok = 1'b1;
      io.inst_sram_rdata   = w[k];
      #1;
      total++;
      if (io.fs_to_ds_valid !== (k == 2)) begin
        bad++;
        $display("FAIL flush_drop%0d got=%0b want=%0b", k,
                 io.fs_to_ds_valid, (k == 2));
      end
      if (k == 2) begin
        total++;
        if (io.fs_to_ds_bus !==
            mk_ds(0, 0, 0, 0, 32'h33333333, 32'hbfc00380)) begin
          bad++;
          $display("FAIL flush_new got=%h want inst=33333333",
                   io.fs_to_ds_bus);
        end
      end
      cyc();
    end
    io.inst_sram_data_ok = 1'b0;
    #1;
    total++;
    if (dut.cancel_cnt !== 2'd0 || io.fs_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_end got cnt=%0d vld=%0b want 0/0",
               dut.cancel_cnt, io.fs_valid);
    end
  endtask

  task automatic test_flush_coincident();
    do_reset();
    io.ds_allowin      = 1'b1;
    io.pfs_to_fs_valid = 1'b1;
    io.pfs_to_fs_bus   = mk_pfs(0, 0, 0, 0, 0, 0, 32'hbfc00020);
    cyc();
    io.pfs_to_fs_valid   = 1'b0;
    io.do_flush          = 1'b1;
    io.inst_sram_data_ok = 1'b1;
    io.inst_sram_rdata   = 32'h12345678;
    #1;
    total++;
    if (io.fs_to_ds_valid !== 1'b0) begin
      bad++;
      $display("FAIL coinc_valid got=%0b want=0", io.fs_to_ds_valid);
    end
    cyc();
    io.do_flush          = 1'b0;
    io.inst_sram_data_ok = 1'b0;
    #1;
    total++;
    if (dut.cancel_cnt !== 2'd0 || io.fs_inst_unable !== 1'b1 ||
        io.fs_valid !== 1'b0) begin
      bad++;
      $display("FAIL coinc_after got cnt=%0d un=%0b vld=%0b want 0/1/0",
               dut.cancel_cnt, io.fs_inst_unable, io.fs_valid);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    io.pfs_to_fs_valid = 1'b1;
    io.pfs_to_fs_bus   = mk_pfs(0, 0, 0, 0, 0, 0, 32'hbfc00030);
    cyc();
    io.pfs_to_fs_valid = 1'b0;
    io.do_flush        = 1'b1;
    cyc();
    io.do_flush        = 1'b0;
    io.pfs_to_fs_valid = 1'b1;
    io.pfs_to_fs_bus   = mk_pfs(1, 0, 0, 5'h03, 32'h1, 0,
                                32'hbfc00040);
    cyc();
    io.pfs_to_fs_valid = 1'b0;
    #1;
    total++;
    if (dut.cancel_cnt !== 2'd1 || io.fs_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre got cnt=%0d vld=%0b want 1/1",
               dut.cancel_cnt, io.fs_valid);
    end
    reset              = 1'b1;
    io.inst_sram_rdata = 32'hffffffff;
    cyc();
    reset = 1'b0;
    #1;
    total++;
    if (io.fs_valid !== 1'b0 || io.fs_allowin !== 1'b1 ||
        io.fs_to_ds_valid !== 1'b0 || io.fs_inst_unable !== 1'b1 ||
        io.fs_to_ds_bus !== 103'd0 || dut.cancel_cnt !== 2'd0) begin
      bad++;
      $display("FAIL midrst got vld=%0b al=%0b dv=%0b un=%0b bus=%h cnt=%0d want 0/1/0/1/0/0",
               io.fs_valid, io.fs_allowin, io.fs_to_ds_valid,
               io.fs_inst_unable, io.fs_to_ds_bus, dut.cancel_cnt);
    end
  endtask

  task automatic test_random();
    slot_t m;
    slot_t e;
    int drop;
    bit req;
    int delivered;
    bit waiting, legal, flush, dok, ds, pv, ok, hit, ready;
    bit ev, ea, eu;
    bit [31:0] rdata, einst;
    do_reset();
    m = '{default: 0};
    drop = 0;
    req = 0;
    delivered = 0;
    for (int c = 0; c < 600; c++) begin
      waiting = m.valid && !m.have && !m.ex;
      legal   = (drop > 0) || waiting || req;
      flush   = ($urandom_range(0, 11) == 0) && (drop < 2);
      dok     = legal && ($urandom_range(0, 1) == 1);
      ds      = ($urandom_range(0, 3) != 0);
      pv      = ($urandom_range(0, 1) == 1);
      rdata   = $urandom;
      e.valid = 1;
      e.ex    = ($urandom_range(0, 5) == 0);
      ok      = ($urandom_range(0, 1) == 1);
      e.have  = ok;
      e.tlb   = ($urandom_range(0, 7) == 0);
      e.ec    = 5'($urandom_range(0, 31));
      e.bv    = $urandom;
      e.pc    = $urandom;
      e.inst  = $urandom;

      io.pfs_to_fs_valid   = pv;
      io.pfs_to_fs_bus     = mk_pfs(e.tlb, ok, e.inst, e.ec, e.bv,
                                    e.ex, e.pc);
      io.pfs_inst_waiting  = req;
      io.inst_sram_data_ok = dok;
      io.inst_sram_rdata   = rdata;
      io.ds_allowin        = ds;
      io.do_flush          = flush;

      hit   = waiting && dok && (drop == 0);
      ready = m.valid && (m.have || m.ex || hit);
      ev    = ready && !flush;
      ea    = !m.valid || (ready && ds);
      eu    = !waiting && (drop == 0);
      einst = m.ex ? 32'd0 : (m.have ? m.inst : rdata);
      #1;
      total++;
      if (io.fs_to_ds_valid !== ev || io.fs_allowin !== ea ||
          io.fs_inst_unable !== eu || io.fs_valid !== m.valid) begin
        bad++;
        $display("FAIL rnd_ctl c=%0d got dv=%0b al=%0b un=%0b v=%0b want %0b/%0b/%0b/%0b",
                 c, io.fs_to_ds_valid, io.fs_allowin, io.fs_inst_unable,
                 io.fs_valid, ev, ea, eu, m.valid);
      end
      total++;
      if (dut.cancel_cnt !== 2'(drop)) begin
        bad++;
        $display("FAIL rnd_cancel c=%0d got=%0d want=%0d",
                 c, dut.cancel_cnt, drop);
      end
      if (ev) begin
        total++;
        if (io.fs_to_ds_bus !==
            mk_ds(m.tlb, m.ec, m.bv, m.ex, einst, m.pc)) begin
          bad++;
          $display("FAIL rnd_bus c=%0d got=%h want=%h", c,
                   io.fs_to_ds_bus,
                   mk_ds(m.tlb, m.ec, m.bv, m.ex, einst, m.pc));
        end
        if (ds) delivered++;
      end

      if (flush) begin
        drop = drop + int'(waiting) + int'(req) - int'(dok);
        req  = 0;
        m.valid = 0;
        m.have  = 0;
        total++;
        if (drop > 3 || drop < 0) begin
          bad++;
          $display("FAIL rnd_cancel_range c=%0d got=%0d want 0..3",
                   c, drop);
          drop = 0;
        end
      end else begin
        if (dok) begin
          if (drop > 0) drop--;
          else if (!waiting) req = 0;
        end
        if (ea) begin
          if (pv) m = e;
          else m.valid = 0;
        end else if (hit) begin
          m.have = 1;
          m.inst = rdata;
        end
        if (!req && $urandom_range(0, 2) == 0) req = 1;
      end
      cyc();
    end
    idle();
    total++;
    if (delivered == 0) begin
      bad++;
      $display("FAIL rnd_delivered got=0 want>0");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_pass_through();
    test_wait_capture();
    test_exception();
    test_flush_cancel();
    test_flush_coincident();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
